// File: rtl/quiz_pkg.sv
// quiz_pkg: shared states, screen codes, button indices and helpers for the
// arrow-quiz round sequencer.
`timescale 1ns/1ps
package quiz_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_SHOW    = 3'd2,
    ST_ANSWER  = 3'd3,
    ST_CORRECT = 3'd4,
    ST_WRONG   = 3'd5,
    ST_RESULT  = 3'd6
  } state_e;

  // Screen codes consumed by the pixel-colour generator
  localparam logic [2:0] SCR_IDLE    = 3'd0;
  localparam logic [2:0] SCR_READY   = 3'd1;
  localparam logic [2:0] SCR_ARROW   = 3'd2;
  localparam logic [2:0] SCR_ANSWER  = 3'd3;
  localparam logic [2:0] SCR_CORRECT = 3'd4;
  localparam logic [2:0] SCR_WRONG   = 3'd5;
  localparam logic [2:0] SCR_RESULT  = 3'd6;

  // Bit positions inside the five-button vector
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_CENTER = 4;

  // Power-on value of the rotation LFSR
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Direction mask (bits {up,down,left,right}) the player must press for a
  // given arrow rotation.
  function automatic logic [3:0] expected_dir(input logic [1:0] rot);
    logic [3:0] mask;
    case (rot)
      2'd0:    mask = 4'b0001;  // right
      2'd1:    mask = 4'b0100;  // down
      2'd2:    mask = 4'b0010;  // left
      default: mask = 4'b1000;  // up
    endcase
    return mask;
  endfunction

  // Screen shown while in a given state
  function automatic logic [2:0] screen_of(input state_e st);
    logic [2:0] scr;
    case (st)
      ST_READY:   scr = SCR_READY;
      ST_SHOW:    scr = SCR_ARROW;
      ST_ANSWER:  scr = SCR_ANSWER;
      ST_CORRECT: scr = SCR_CORRECT;
      ST_WRONG:   scr = SCR_WRONG;
      ST_RESULT:  scr = SCR_RESULT;
      default:    scr = SCR_IDLE;
    endcase
    return scr;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, level debouncer and rising-edge pulse
// for one push button.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic i_raw,
  output logic o_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Bring the raw level into the clock domain
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample matching the accepted level restarts the count.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_pulse <= r_sync2;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_pulse <= 1'b0;
      end
    end else begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/quiz_round_seq.sv
// quiz_round_seq: one arrow-quiz round (idle, get-ready, NUM_Q questions,
// result). Optional macro QUIZ_LFSR_EN picks rotations from a 16-bit LFSR
// instead of the fixed 0,1,2,3 order.
`timescale 1ns/1ps
module quiz_round_seq
  import quiz_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP  = 100_000_000,
  parameter int unsigned ANSWER_TICKS    = 300_000_000,
  parameter int unsigned FEEDBACK_TICKS  = 50_000_000,
  parameter int unsigned NUM_Q           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic [4:0] fivebuttons,
  output logic [1:0] o_mode,
  output logic [2:0] o_screen,
  output logic [3:0] o_score,
  output logic [3:0] o_qidx,
  output logic       o_done
);

  logic [4:0]  w_pulse;
  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_timer;
  logic [31:0] w_timer_load;
  logic [3:0]  r_score;
  logic [3:0]  w_score_next;
  logic [3:0]  r_qidx;
  logic [3:0]  w_qidx_next;
  logic [1:0]  r_mode;
  logic [1:0]  w_rot;
  logic [2:0]  r_screen;
  logic        r_done;
  logic        w_expired;
  logic        w_entry;
  logic [3:0]  w_dir;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .i_raw   (fivebuttons[gi]),
        .o_pulse (w_pulse[gi])
      );
    end
  endgenerate

  assign w_expired = (r_timer == 32'd0);
  assign w_entry   = (w_state_next != r_state);
  assign w_dir     = w_pulse[BTN_UP:BTN_RIGHT];

`ifdef QUIZ_LFSR_EN
  logic [15:0] r_lfsr;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_rot = r_lfsr[1:0];
`else
  // Fixed order: rotation follows the question index about to be shown
  assign w_rot = w_qidx_next[1:0];
`endif

  // Next-state, score and question-index decisions
  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    w_qidx_next  = r_qidx;
    case (r_state)
      ST_IDLE: begin
        if (w_pulse[BTN_CENTER]) begin
          w_state_next = ST_READY;
          w_score_next = 4'd0;
          w_qidx_next  = 4'd0;
        end
      end
      ST_READY:  if (w_expired) w_state_next = ST_SHOW;
      ST_SHOW:   if (w_expired) w_state_next = ST_ANSWER;
      ST_ANSWER: begin
        // A press outranks a coinciding timeout; multi-press counts as wrong
        if (|w_dir) begin
          if ($onehot(w_dir) && (w_dir == expected_dir(r_mode))) begin
            w_state_next = ST_CORRECT;
            w_score_next = (r_score == 4'd15) ? r_score : r_score + 4'd1;
          end else begin
            w_state_next = ST_WRONG;
          end
        end else if (w_expired) begin
          w_state_next = ST_WRONG;
        end
      end
      ST_CORRECT, ST_WRONG: begin
        if (w_expired) begin
          if (r_qidx == 4'(NUM_Q - 1)) begin
            w_state_next = ST_RESULT;
          end else begin
            w_state_next = ST_SHOW;
            w_qidx_next  = r_qidx + 4'd1;
          end
        end
      end
      ST_RESULT: if (w_pulse[BTN_CENTER]) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Dwell time for the state being entered
  always_comb begin
    w_timer_load = 32'd0;
    case (w_state_next)
      ST_READY, ST_SHOW:    w_timer_load = 32'(TICKS_PER_STEP - 1);
      ST_ANSWER:            w_timer_load = 32'(ANSWER_TICKS - 1);
      ST_CORRECT, ST_WRONG: w_timer_load = 32'(FEEDBACK_TICKS - 1);
      default:              w_timer_load = 32'd0;
    endcase
  end

  // State, timer and registered outputs
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= 32'd0;
      r_score  <= 4'd0;
      r_qidx   <= 4'd0;
      r_mode   <= 2'd0;
      r_screen <= SCR_IDLE;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_score  <= w_score_next;
      r_qidx   <= w_qidx_next;
      r_screen <= screen_of(w_state_next);
      r_done   <= w_entry && (w_state_next == ST_RESULT);
      if (w_entry)                r_timer <= w_timer_load;
      else if (r_timer != 32'd0)  r_timer <= r_timer - 32'd1;
      if (w_entry && (w_state_next == ST_SHOW)) r_mode <= w_rot;
    end
  end

  assign o_mode   = r_mode;
  assign o_screen = r_screen;
  assign o_score  = r_score;
  assign o_qidx   = r_qidx;
  assign o_done   = r_done;

endmodule

// File: tb/tb_quiz_round_seq.sv
// tb_quiz_round_seq: directed scenario tests for quiz_round_seq with small
// timing parameters and the fixed rotation order.
`timescale 1ns/1ps
module tb_quiz_round_seq;
  import quiz_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btns = 5'd0;
  logic [1:0] o_mode;
  logic [2:0] o_screen;
  logic [3:0] o_score;
  logic [3:0] o_qidx;
  logic       o_done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  localparam logic [4:0] B_RIGHT  = 5'b00001;
  localparam logic [4:0] B_LEFT   = 5'b00010;
  localparam logic [4:0] B_DOWN   = 5'b00100;
  localparam logic [4:0] B_UP     = 5'b01000;
  localparam logic [4:0] B_CENTER = 5'b10000;

  quiz_round_seq #(
    .TICKS_PER_STEP (8),
    .ANSWER_TICKS   (20),
    .FEEDBACK_TICKS (4),
    .NUM_Q          (4),
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .w_clk      (clk),
    .w_rst_n    (rst_n),
    .fivebuttons(btns),
    .o_mode     (o_mode),
    .o_screen   (o_screen),
    .o_score    (o_score),
    .o_qidx     (o_qidx),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && o_done) done_cnt++;

  task automatic wait_screen(input logic [2:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_screen === code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    btns = mask;
    repeat (hold) @(negedge clk);
    btns = 5'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btns  = 5'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Center press from IDLE, returns once READY is showing
  task automatic start_round(output bit ok);
    press(B_CENTER, 4);
    wait_screen(SCR_READY, 20, ok);
  endtask

  // Wait through SHOW into ANSWER
  task automatic to_answer(output bit ok);
    bit ok1;
    bit ok2;
    wait_screen(SCR_ARROW, 30, ok1);
    wait_screen(SCR_ANSWER, 20, ok2);
    ok = ok1 && ok2;
  endtask

  // Count cycles spent in ANSWER (already observed once) until it leaves
  task automatic count_answer(output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_screen === SCR_ANSWER) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    btns  = 5'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_mode, o_screen, o_score, o_qidx, o_done} !== 14'd0) begin
      failures++;
      $display("FAIL reset_values: mode=%0d screen=%0d score=%0d qidx=%0d done=%0d required all 0",
               o_mode, o_screen, o_score, o_qidx, o_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    press(B_RIGHT | B_LEFT | B_UP | B_DOWN, 4);
    wait_screen(SCR_READY, 8, ok);
    checks++;
    if (ok || o_screen !== SCR_IDLE) begin
      failures++;
      $display("FAIL idle_ignores_dirs: screen=%0d required %0d", o_screen, SCR_IDLE);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_round();
    bit ok;
    int d0;
    logic [4:0] ans [4];
    ans[0] = B_RIGHT; ans[1] = B_DOWN; ans[2] = B_LEFT; ans[3] = B_UP;
    do_reset();
    d0 = done_cnt;
    start_round(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_ready: screen=%0d required %0d", o_screen, SCR_READY);
    end
    for (int q = 0; q < 4; q++) begin
      wait_screen(SCR_ARROW, 30, ok);
      checks++;
      if (!ok || o_mode !== 2'(q) || o_qidx !== 4'(q)) begin
        failures++;
        $display("FAIL full_show_q%0d: screen=%0d mode=%0d qidx=%0d required screen=2 mode=%0d qidx=%0d",
                 q, o_screen, o_mode, o_qidx, q, q);
      end
      wait_screen(SCR_ANSWER, 20, ok);
      press(ans[q], 4);
      wait_screen(SCR_CORRECT, 10, ok);
      checks++;
      if (!ok || o_score !== 4'(q + 1) || o_mode !== 2'(q)) begin
        failures++;
        $display("FAIL full_correct_q%0d: screen=%0d score=%0d mode=%0d required screen=4 score=%0d mode=%0d",
                 q, o_screen, o_score, o_mode, q + 1, q);
      end
    end
    wait_screen(SCR_RESULT, 20, ok);
    checks++;
    if (!ok || o_done !== 1'b1 || o_score !== 4'd4 || o_qidx !== 4'd3) begin
      failures++;
      $display("FAIL full_result: screen=%0d done=%0d score=%0d qidx=%0d required screen=6 done=1 score=4 qidx=3",
               o_screen, o_done, o_score, o_qidx);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || (done_cnt - d0) != 1 || o_screen !== SCR_RESULT) begin
      failures++;
      $display("FAIL full_done_pulse: done=%0d pulses=%0d screen=%0d required done=0 pulses=1 screen=6",
               o_done, done_cnt - d0, o_screen);
    end
    press(B_CENTER, 4);
    wait_screen(SCR_IDLE, 10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_back_to_idle: screen=%0d required %0d", o_screen, SCR_IDLE);
    end
    $display("test_full_round done");
  endtask

  task automatic test_wrong_timeout();
    bit ok;
    int n;
    do_reset();
    start_round(ok);
    to_answer(ok);
    press(B_UP, 4);
    wait_screen(SCR_WRONG, 10, ok);
    checks++;
    if (!ok || o_score !== 4'd0) begin
      failures++;
      $display("FAIL wrong_q0: screen=%0d score=%0d required screen=5 score=0", o_screen, o_score);
    end
    wait_screen(SCR_ARROW, 30, ok);
    checks++;
    if (!ok || o_qidx !== 4'd1 || o_mode !== 2'd1) begin
      failures++;
      $display("FAIL wrong_next_q: qidx=%0d mode=%0d required qidx=1 mode=1", o_qidx, o_mode);
    end
    wait_screen(SCR_ANSWER, 20, ok);
    count_answer(n);
    checks++;
    if (n != 20 || o_screen !== SCR_WRONG || o_score !== 4'd0) begin
      failures++;
      $display("FAIL timeout_q1: answer_cycles=%0d screen=%0d score=%0d required 20 cycles screen=5 score=0",
               n, o_screen, o_score);
    end
    wait_screen(SCR_ARROW, 30, ok);
    checks++;
    if (!ok || o_qidx !== 4'd2 || o_score !== 4'd0) begin
      failures++;
      $display("FAIL timeout_advance: qidx=%0d score=%0d required qidx=2 score=0", o_qidx, o_score);
    end
    $display("test_wrong_timeout done");
  endtask

  task automatic test_debounce();
    bit ok;
    do_reset();
    start_round(ok);
    to_answer(ok);
    press(B_RIGHT, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (o_screen !== SCR_ANSWER || o_score !== 4'd0) begin
      failures++;
      $display("FAIL debounce_glitch: screen=%0d score=%0d required screen=3 score=0", o_screen, o_score);
    end
    press(B_RIGHT, 3);
    wait_screen(SCR_CORRECT, 6, ok);
    checks++;
    if (!ok || o_score !== 4'd1) begin
      failures++;
      $display("FAIL debounce_hold: screen=%0d score=%0d required screen=4 score=1", o_screen, o_score);
    end
    wait_screen(SCR_ARROW, 20, ok);
    checks++;
    if (!ok || o_qidx !== 4'd1 || o_score !== 4'd1) begin
      failures++;
      $display("FAIL debounce_single: qidx=%0d score=%0d required qidx=1 score=1", o_qidx, o_score);
    end
    $display("test_debounce done");
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    start_round(ok);
    to_answer(ok);
    press(B_RIGHT | B_LEFT, 4);
    wait_screen(SCR_WRONG, 10, ok);
    checks++;
    if (!ok || o_score !== 4'd0) begin
      failures++;
      $display("FAIL simultaneous: screen=%0d score=%0d required screen=5 score=0", o_screen, o_score);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_early_press();
    bit ok;
    int n;
    do_reset();
    start_round(ok);
    wait_screen(SCR_ARROW, 30, ok);
    repeat (2) @(negedge clk);
    btns = B_RIGHT;
    wait_screen(SCR_ANSWER, 20, ok);
    count_answer(n);
    btns = 5'd0;
    checks++;
    if (!ok || n != 20 || o_screen !== SCR_WRONG || o_score !== 4'd0) begin
      failures++;
      $display("FAIL early_press: answer_cycles=%0d screen=%0d score=%0d required 20 cycles screen=5 score=0",
               n, o_screen, o_score);
    end
    $display("test_early_press done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    start_round(ok);
    to_answer(ok);
    press(B_RIGHT, 4);
    wait_screen(SCR_CORRECT, 10, ok);
    to_answer(ok);
    press(B_DOWN, 4);
    wait_screen(SCR_CORRECT, 10, ok);
    to_answer(ok);
    checks++;
    if (!ok || o_score !== 4'd2 || o_qidx !== 4'd2 || o_mode !== 2'd2) begin
      failures++;
      $display("FAIL mid_setup: screen=%0d score=%0d qidx=%0d mode=%0d required screen=3 score=2 qidx=2 mode=2",
               o_screen, o_score, o_qidx, o_mode);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mode, o_screen, o_score, o_qidx, o_done} !== 14'd0) begin
      failures++;
      $display("FAIL mid_async_reset: mode=%0d screen=%0d score=%0d qidx=%0d done=%0d required all 0",
               o_mode, o_screen, o_score, o_qidx, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_screen !== SCR_IDLE || o_score !== 4'd0) begin
      failures++;
      $display("FAIL mid_stays_idle: screen=%0d score=%0d required screen=0 score=0", o_screen, o_score);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_wrong_timeout();
    test_debounce();
    test_simultaneous();
    test_early_press();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
